// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Holds the arbiter state enum, default limits and the abort data value.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_TIMEOUT    = 15;
  localparam int unsigned DEF_STARVE_LIM = 2;

  // Read data returned on an aborted access.
  localparam int unsigned ABORT_DATA = 0;

  // Bits needed to hold the values 0..n (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Loadable up/down counter with clear, enable and an expire flag.
// Ports: clk, rst, clr_i, load_i, load_val_i, en_i, up_i -> expire_o.
module wait_timer
  import riscv_mem_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_TIMEOUT,
  parameter int unsigned WIDTH = cnt_w(LIMIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic             expire_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = up_i ? cnt_q + WIDTH'(1)
                   : cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High on the enabled up-count that brings the count to LIMIT.
  assign expire_o = en_i & up_i & ~clr_i
                  & ~load_i & (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data accesses onto one single-port memory.
// Ports: fetch (if_*), data (d_*), stalls, memory (m_*), timeout_err.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              stall_if,
  output logic              stall_d,
  output logic              m_valid,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              timeout_err
);

  localparam int unsigned SW = cnt_w(STARVE_LIM);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_LIM);

  arb_state_e        state_q;
  logic              m_valid_q;
  logic              m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_done_q;
  logic              d_done_q;
  logic              terr_q;
  logic [SW-1:0]     starve_q;
  logic [SW-1:0]     starve_d;

  logic              d_pend;
  logic              i_pend;
  logic              starved;
  logic              pick_d;
  logic              pick_i;
  logic              in_gnt;
  logic              expire;
  logic              leave;
  logic [DATA_W-1:0] fin_data;

  // A request is ignored in the cycle its own done pulse is out.
  assign d_pend  = d_req & ~d_done_q;
  assign i_pend  = if_req & ~if_done_q;
  assign starved = (starve_q == S_MAX);

  assign pick_d = d_pend & (~i_pend | ~starved);
  assign pick_i = i_pend & ~pick_d;

  assign in_gnt = (state_q != IDLE);

  wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (~in_gnt | m_ready),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (in_gnt & ~m_ready),
    .up_i       (1'b1),
    .expire_o   (expire)
  );

  // m_ready on the expiring cycle still completes normally.
  assign leave    = m_ready | expire;
  assign fin_data = m_ready ? m_rdata
                            : DATA_W'(ABORT_DATA);

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      unique case (1'b1)
        pick_d: begin
          if (!i_pend) begin
            starve_d = '0;
          end else if (!starved) begin
            starve_d = starve_q + SW'(1);
          end
        end
        pick_i:  starve_d = '0;
        default: starve_d = starve_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      m_valid_q  <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      terr_q     <= 1'b0;
      starve_q   <= '0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      starve_q  <= starve_d;
      unique case (state_q)
        IDLE: begin
          if (pick_d) begin
            state_q   <= GNT_D;
            m_valid_q <= 1'b1;
            m_we_q    <= d_we;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
          end else if (pick_i) begin
            state_q   <= GNT_I;
            m_valid_q <= 1'b1;
            m_we_q    <= 1'b0;
            m_addr_q  <= if_addr;
            m_wdata_q <= '0;
          end
        end
        GNT_D: begin
          if (leave) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            d_done_q  <= 1'b1;
            d_rdata_q <= fin_data;
            if (!m_ready) terr_q <= 1'b1;
          end
        end
        GNT_I: begin
          if (leave) begin
            state_q    <= IDLE;
            m_valid_q  <= 1'b0;
            if_done_q  <= 1'b1;
            if_rdata_q <= fin_data;
            if (!m_ready) terr_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid     = m_valid_q;
  assign m_we        = m_we_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_done     = if_done_q;
  assign d_done      = d_done_q;
  assign timeout_err = terr_q;

  assign stall_if = if_req & ~if_done_q;
  assign stall_d  = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic.
// Every cycle is compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int TO = 15;
  localparam int SL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        stall_if;
  logic        stall_d;
  logic        m_valid;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        timeout_err;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .TIMEOUT    (TO),
    .STARVE_LIM (SL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_done     (if_done),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_done      (d_done),
    .stall_if    (stall_if),
    .stall_d     (stall_d),
    .m_valid     (m_valid),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_ready     (m_ready),
    .m_rdata     (m_rdata),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  // Reference model: which port owns the memory (0 none, 1 data,
  // 2 fetch), the latched request, wait cycles so far, pending done
  // pulses, returned data, sticky error and consecutive data wins.
  int          owner;
  bit          t_we;
  bit   [31:0] t_addr;
  bit   [31:0] t_wdata;
  int          waits;
  bit          e_ifd;
  bit          e_dd;
  bit   [31:0] e_ifr;
  bit   [31:0] e_dr;
  bit          e_terr;
  int          starve;

  task automatic mdl_step(input bit r);
    bit          nd_i;
    bit          nd_d;
    bit          dp;
    bit          ip;
    int          win;
    bit   [31:0] val;
    if (r) begin
      owner = 0; waits = 0; starve = 0;
      e_ifd = 0; e_dd = 0; e_terr = 0;
      e_ifr = 0; e_dr = 0;
      return;
    end
    nd_i = 0;
    nd_d = 0;
    if (owner != 0) begin
      if (m_ready || waits + 1 == TO) begin
        val = m_ready ? m_rdata : 32'd0;
        if (!m_ready) e_terr = 1;
        if (owner == 1) begin
          nd_d = 1; e_dr = val;
        end else begin
          nd_i = 1; e_ifr = val;
        end
        owner = 0;
        waits = 0;
      end else begin
        waits++;
      end
    end else begin
      dp = d_req && !e_dd;
      ip = if_req && !e_ifd;
      win = 0;
      if (dp && ip) win = (starve >= SL) ? 2 : 1;
      else if (dp)  win = 1;
      else if (ip)  win = 2;
      if (win == 1) begin
        owner = 1;
        t_we = d_we; t_addr = d_addr; t_wdata = d_wdata;
        starve = ip ? ((starve + 1 > SL) ? SL : starve + 1) : 0;
      end else if (win == 2) begin
        owner = 2;
        t_we = 0; t_addr = if_addr; t_wdata = 0;
        starve = 0;
      end
    end
    e_ifd = nd_i;
    e_dd  = nd_d;
  endtask

  // One cycle: drive inputs after the falling edge, compare outputs,
  // then advance the model across the coming rising edge.
  task automatic cyc(input bit r,
                     input bit ir, input bit [31:0] ia,
                     input bit dr, input bit dw,
                     input bit [31:0] da, input bit [31:0] dwd,
                     input bit mr, input bit [31:0] mrd);
    rst = r; if_req = ir; if_addr = ia;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    m_ready = mr; m_rdata = mrd;
    #1;
    chk("m_valid", m_valid, owner != 0);
    if (owner != 0) begin
      chk("m_we", m_we, t_we);
      chk("m_addr", m_addr, t_addr);
      chk("m_wdata", m_wdata, t_wdata);
    end
    chk("if_done", if_done, e_ifd);
    chk("d_done", d_done, e_dd);
    chk("if_rdata", if_rdata, e_ifr);
    chk("d_rdata", d_rdata, e_dr);
    chk("timeout_err", timeout_err, e_terr);
    chk("stall_if", stall_if, ir && !e_ifd);
    chk("stall_d", stall_d, dr && !e_dd);
    mdl_step(r);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  bit slow;

  initial begin
    rst = 1; if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    m_ready = 0; m_rdata = 0;
    mdl_step(1);
    repeat (2) @(negedge clk);

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_we", m_we, 0);
    idle(2);

    // Single fetch, ready in cycle 1.
    cyc(0, 1, 32'h10, 0, 0, 0, 0, 0, 0);
    chk("fetch_addr", m_addr, 32'h10);
    cyc(0, 1, 32'h10, 0, 0, 0, 0, 1, 32'h00500093);
    chk("fetch_done", if_done, 1);
    chk("fetch_data", if_rdata, 32'h00500093);
    cyc(0, 1, 32'h10, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Simultaneous: the store wins, fetch follows at d_done.
    cyc(0, 1, 32'h14, 1, 1, 32'h40, 32'hA5A5A5A5, 0, 0);
    chk("sim_we", m_we, 1);
    chk("sim_addr", m_addr, 32'h40);
    cyc(0, 1, 32'h14, 1, 1, 32'h40, 32'hA5A5A5A5, 1, 32'h5555);
    cyc(0, 1, 32'h14, 1, 1, 32'h40, 32'hA5A5A5A5, 0, 0);
    chk("sim_f_we", m_we, 0);
    chk("sim_f_addr", m_addr, 32'h14);
    cyc(0, 1, 32'h14, 0, 0, 0, 0, 1, 32'h77);
    chk("sim_if_done", if_done, 1);
    cyc(0, 1, 32'h14, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Two data wins with fetch pending, then fetch is forced in.
    cyc(0, 1, 32'h20, 1, 0, 32'h80, 0, 0, 0);
    cyc(0, 1, 32'h20, 1, 0, 32'h80, 0, 1, 32'h1);
    cyc(0, 0, 32'h20, 1, 0, 32'h80, 0, 0, 0);
    cyc(0, 1, 32'h20, 1, 0, 32'h84, 0, 0, 0);
    cyc(0, 1, 32'h20, 1, 0, 32'h84, 0, 1, 32'h2);
    cyc(0, 0, 32'h20, 1, 0, 32'h84, 0, 0, 0);
    cyc(0, 1, 32'h20, 1, 0, 32'h88, 0, 0, 0);
    chk("starve_we", m_we, 0);
    chk("starve_addr", m_addr, 32'h20);
    cyc(0, 1, 32'h20, 1, 0, 32'h88, 0, 1, 32'h3);
    cyc(0, 1, 32'h20, 1, 0, 32'h88, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 32'h88, 0, 1, 32'h4);
    cyc(0, 0, 0, 1, 0, 32'h88, 0, 0, 0);
    idle(2);

    // Timeout on a load.
    for (int i = 0; i < TO + 1; i++)
      cyc(0, 0, 0, 1, 0, 32'h90, 0, 0, 0);
    chk("to_done", d_done, 1);
    chk("to_data", d_rdata, 0);
    chk("to_err", timeout_err, 1);
    cyc(0, 0, 0, 1, 0, 32'h90, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 1, 1, 32'h94, 32'h9, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h94, 32'h9, 1, 32'hAB);
    chk("after_to_done", d_done, 1);
    chk("err_sticky", timeout_err, 1);
    cyc(0, 0, 0, 1, 1, 32'h94, 32'h9, 0, 0);

    // Ready on the last allowed wait cycle completes normally.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO; i++)
      cyc(0, 0, 0, 1, 0, 32'hA0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 32'hA0, 0, 1, 32'h1234);
    chk("race_done", d_done, 1);
    chk("race_data", d_rdata, 32'h1234);
    chk("race_err", timeout_err, 0);
    cyc(0, 0, 0, 1, 0, 32'hA0, 0, 0, 0);
    idle(1);

    // Reset while a fetch waits for memory.
    cyc(0, 1, 32'hC0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hC0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'hC0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_valid", m_valid, 0);
    chk("rst_mid_done", if_done, 0);
    cyc(0, 1, 32'hC0, 0, 0, 0, 0, 0, 0);
    chk("rearb_valid", m_valid, 1);
    cyc(0, 1, 32'hC0, 0, 0, 0, 0, 1, 32'hCC);
    cyc(0, 1, 32'hC0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Random traffic with fast and slow memory phases.
    slow = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 64 == 0) slow = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(0, 249) == 0,
          $urandom_range(0, 9) < 7, $urandom,
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 1) == 1,
          $urandom, $urandom,
          slow ? ($urandom_range(0, 19) == 0)
               : ($urandom_range(0, 1) == 1),
          $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
